// File: rtl/adc_spi_sequencer.sv
// -----------------------------------------------------------------------------
// adc_spi_sequencer
//
// Serial initiator for an 8-channel, 12-bit ADC. A channel command goes in,
// and one 12-bit result for that channel comes back. The ADC returns the
// conversion of the address sent in the previous frame. For that reason a
// command takes two frames, unless the last completed frame already addressed
// the requested channel.
//
// Handshake: a command is transferred on a rising edge where io_cmd_valid and
// io_cmd_ready are both high. io_cmd_ready is high only in IDLE, so the
// initiator must hold io_cmd_valid and io_cmd_channel until that edge.
// io_rsp_valid is a one-cycle pulse with no backpressure. io_rsp_data and
// io_rsp_channel hold their value until the next response.
//
// Ports
//   io_axiClk       clock
//   io_reset        synchronous, active-high reset
//   io_cmd_valid    command present
//   io_cmd_ready    block is IDLE and can take a command
//   io_cmd_channel  requested channel 0..7
//   io_rsp_valid    one-cycle result strobe
//   io_rsp_channel  channel of io_rsp_data
//   io_rsp_data     12-bit conversion result
//   io_busy         state is not IDLE
//   adc_cs_n        ADC chip select, active low
//   adc_sclk        ADC serial clock, idles high
//   adc_saddr       address bit to the ADC
//   adc_sdat        data bit from the ADC
//   o_dbg_state     current FSM state, for observation only
// -----------------------------------------------------------------------------
module adc_spi_sequencer #(
    parameter int CLK_DIV = 25  // clock cycles per SCLK half-period, >= 2
) (
    input  logic        io_axiClk,
    input  logic        io_reset,
    input  logic        io_cmd_valid,
    output logic        io_cmd_ready,
    input  logic [2:0]  io_cmd_channel,
    output logic        io_rsp_valid,
    output logic [2:0]  io_rsp_channel,
    output logic [11:0] io_rsp_data,
    output logic        io_busy,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_saddr,
    input  logic        adc_sdat,
    output logic [2:0]  o_dbg_state
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_k;
    logic             r_gap_half;     // GAP is two divider periods long
    logic [1:0]       r_frames_left;
    logic [2:0]       r_channel;
    logic [2:0]       r_last_addr;
    logic             r_addr_valid;
    // Only the last 12 sampled bits (D11..D0) are kept. The four leading
    // bits of each frame shift out of the top.
    logic [11:0]      r_shift;
    logic             r_cs_n;
    logic             r_sclk;
    logic             r_saddr;
    logic             r_rsp_valid;
    logic [11:0]      r_rsp_data;
    logic [2:0]       r_rsp_channel;

    logic             w_div_end;
    logic             w_same_addr;

    assign w_div_end   = (r_div == DIV_LAST);
    assign w_same_addr = r_addr_valid && (r_last_addr == io_cmd_channel);

    // Address bit for frame bit k: bits 2, 3 and 4 carry ADD2, ADD1, ADD0.
    function automatic logic f_addr_bit(input logic [3:0] k, input logic [2:0] ch);
        logic b;
        case (k)
            4'd2:    b = ch[2];
            4'd3:    b = ch[1];
            4'd4:    b = ch[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            r_state       <= S_IDLE;
            r_div         <= '0;
            r_k           <= '0;
            r_gap_half    <= 1'b0;
            r_frames_left <= 2'd0;
            r_channel     <= 3'd0;
            r_last_addr   <= 3'd0;
            r_addr_valid  <= 1'b0;
            r_shift       <= '0;
            r_cs_n        <= 1'b1;
            r_sclk        <= 1'b1;
            r_saddr       <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_channel <= 3'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_saddr <= 1'b0;
                    r_div   <= '0;
                    if (io_cmd_valid) begin
                        r_channel     <= io_cmd_channel;
                        r_frames_left <= w_same_addr ? 2'd1 : 2'd2;
                        r_cs_n        <= 1'b0;
                        r_state       <= S_START;
                    end
                end

                // CS setup: CS low with SCLK still high for one half-period.
                S_START: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_k     <= 4'd0;
                        r_sclk  <= 1'b0;
                        r_saddr <= f_addr_bit(4'd0, r_channel);
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                // SADDR changes together with the falling SCLK. SDAT is
                // captured together with the rising SCLK, which is half a period
                // after the ADC moved it on the falling edge.
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[10:0], adc_sdat};
                        end else if (r_k == 4'd15) begin
                            r_cs_n     <= 1'b1;
                            r_saddr    <= 1'b0;
                            r_gap_half <= 1'b0;
                            r_state    <= S_GAP;
                        end else begin
                            r_k     <= r_k + 4'd1;
                            r_sclk  <= 1'b0;
                            r_saddr <= f_addr_bit(r_k + 4'd1, r_channel);
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_GAP: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (!r_gap_half) begin
                            r_gap_half <= 1'b1;
                        end else begin
                            r_gap_half   <= 1'b0;
                            r_last_addr  <= r_channel;
                            r_addr_valid <= 1'b1;
                            if (r_frames_left == 2'd2) begin
                                // The first frame only loaded the address.
                                // Its data belongs to an older address.
                                r_frames_left <= 2'd1;
                                r_cs_n        <= 1'b0;
                                r_state       <= S_START;
                            end else begin
                                r_rsp_valid   <= 1'b1;
                                r_rsp_data    <= r_shift;
                                r_rsp_channel <= r_channel;
                                r_state       <= S_DONE;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_cmd_ready   = (r_state == S_IDLE);
    assign io_busy        = (r_state != S_IDLE);
    assign io_rsp_valid   = r_rsp_valid;
    assign io_rsp_data    = r_rsp_data;
    assign io_rsp_channel = r_rsp_channel;
    assign adc_cs_n       = r_cs_n;
    assign adc_sclk       = r_sclk;
    assign adc_saddr      = r_saddr;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed bench for adc_spi_sequencer. The bench uses two instances:
// u_dut_a with CLK_DIV=4 and u_dut_b with CLK_DIV=2. A behavioural ADC is
// attached to each instance. Each ADC model returns the value of the address
// from its previous complete frame. It drives SDAT on the falling SCLK edges
// and records the SADDR word of every complete frame.
module tb_adc_spi_sequencer;
  localparam int DIV_A = 4;
  localparam int DIV_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       cmd_valid;
  logic [2:0] cmd_channel;
  logic       sel_b;
  logic       valid_a, valid_b;
  assign valid_a = cmd_valid && !sel_b;
  assign valid_b = cmd_valid && sel_b;

  logic        ready_a, rspv_a, busy_a, cs_a, sclk_a, saddr_a;
  logic [2:0]  rspch_a, dbg_a;
  logic [11:0] rspd_a;
  logic        sdat_a = 1'b0;
  logic        ready_b, rspv_b, busy_b, cs_b, sclk_b, saddr_b;
  logic [2:0]  rspch_b, dbg_b;
  logic [11:0] rspd_b;
  logic        sdat_b = 1'b0;

  adc_spi_sequencer #(.CLK_DIV(DIV_A)) u_dut_a (
    .io_axiClk(clk), .io_reset(rst), .io_cmd_valid(valid_a), .io_cmd_ready(ready_a),
    .io_cmd_channel(cmd_channel), .io_rsp_valid(rspv_a), .io_rsp_channel(rspch_a),
    .io_rsp_data(rspd_a), .io_busy(busy_a), .adc_cs_n(cs_a), .adc_sclk(sclk_a),
    .adc_saddr(saddr_a), .adc_sdat(sdat_a), .o_dbg_state(dbg_a)
  );

  adc_spi_sequencer #(.CLK_DIV(DIV_B)) u_dut_b (
    .io_axiClk(clk), .io_reset(rst), .io_cmd_valid(valid_b), .io_cmd_ready(ready_b),
    .io_cmd_channel(cmd_channel), .io_rsp_valid(rspv_b), .io_rsp_channel(rspch_b),
    .io_rsp_data(rspd_b), .io_busy(busy_b), .adc_cs_n(cs_b), .adc_sclk(sclk_b),
    .adc_saddr(saddr_b), .adc_sdat(sdat_b), .o_dbg_state(dbg_b)
  );

  // View of whichever instance the current step drives
  logic        t_ready, t_rspv, t_busy;
  logic [2:0]  t_rspch;
  logic [11:0] t_rspd;
  assign t_ready = sel_b ? ready_b : ready_a;
  assign t_rspv  = sel_b ? rspv_b  : rspv_a;
  assign t_busy  = sel_b ? busy_b  : busy_a;
  assign t_rspch = sel_b ? rspch_b : rspch_a;
  assign t_rspd  = sel_b ? rspd_b  : rspd_a;

  // ---------------- ADC models ----------------
  logic [15:0] saddr_q[$];

  logic [11:0] val_a [8];
  logic [15:0] word_a;
  logic [15:0] sa_a;
  logic [2:0]  prev_a = 3'd0;
  int rise_a = 0, fall_a = 0, frames_a = 0;

  always @(negedge cs_a) begin
    word_a = {4'hA, val_a[prev_a]};
    rise_a = 0; fall_a = 0; sa_a = '0;
  end
  always @(negedge sclk_a) if (cs_a === 1'b0 && fall_a < 16) begin
    sdat_a = word_a[15 - fall_a];
    fall_a++;
  end
  always @(posedge sclk_a) if (cs_a === 1'b0) begin
    sa_a = {sa_a[14:0], saddr_a};
    rise_a++;
  end
  always @(posedge cs_a) if (rise_a == 16) begin
    frames_a++;
    prev_a = sa_a[13:11];
    saddr_q.push_back(sa_a);
    rise_a = 0;
  end

  logic [11:0] val_b [8];
  logic [15:0] word_b;
  logic [15:0] sa_b;
  logic [2:0]  prev_b = 3'd0;
  int rise_b = 0, fall_b = 0, frames_b = 0;
  longint fall_t_b = 0;
  int per_b = 0, low_b = 0;

  always @(negedge cs_b) begin
    word_b = {4'hF, val_b[prev_b]};  // leading bits forced high
    rise_b = 0; fall_b = 0; sa_b = '0;
  end
  always @(negedge sclk_b) if (cs_b === 1'b0 && fall_b < 16) begin
    sdat_b = word_b[15 - fall_b];
    if (fall_b > 0) per_b = int'(($time - fall_t_b) / 10);
    fall_t_b = $time;
    fall_b++;
  end
  always @(posedge sclk_b) if (cs_b === 1'b0) begin
    sa_b = {sa_b[14:0], saddr_b};
    low_b = int'(($time - fall_t_b) / 10);
    rise_b++;
  end
  always @(posedge cs_b) if (rise_b == 16) begin
    frames_b++;
    prev_b = sa_b[13:11];
    saddr_q.push_back(sa_b);
    rise_b = 0;
  end

  // ---------------- checking ----------------
  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One complete command: accept, latency, result, frame count and SADDR words
  task automatic run_cmd(input bit use_b, input logic [2:0] ch, input int n_frames,
                         input logic [11:0] exp_data, input logic [15:0] exp_word,
                         input string tag);
    int div, c0, f0, waited;
    div = use_b ? DIV_B : DIV_A;
    sel_b = use_b;
    @(negedge clk);
    waited = 0;
    while (t_ready !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
    check({tag, "_ready"}, 32'(t_ready), 32'd1);
    saddr_q.delete();
    f0 = use_b ? frames_b : frames_a;
    cmd_channel = ch;
    cmd_valid = 1'b1;
    @(negedge clk);
    c0 = cyc;
    cmd_valid = 1'b0;
    check({tag, "_busy"}, 32'({t_busy, t_ready}), 32'h2);
    waited = 0;
    while (t_rspv !== 1'b1 && waited < 100 * div) begin @(negedge clk); waited++; end
    check({tag, "_latency"}, 32'(cyc - c0), 32'(n_frames * 35 * div));
    check({tag, "_data"}, 32'(t_rspd), 32'(exp_data));
    check({tag, "_chan"}, 32'(t_rspch), 32'(ch));
    check({tag, "_frames"}, 32'((use_b ? frames_b : frames_a) - f0), 32'(n_frames));
    check({tag, "_nwords"}, 32'(saddr_q.size()), 32'(n_frames));
    foreach (saddr_q[i]) check({tag, "_saddr"}, 32'(saddr_q[i]), 32'(exp_word));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(t_rspv), 32'd0);
    check({tag, "_hold"}, 32'(t_rspd), 32'(exp_data));
  endtask

  initial begin
    int c0, c1, waited, n_rsp, bad_ready, t_rsp1, t_rsp2, t_acc, extra;
    logic [11:0] d1, d2;
    logic [2:0] ch1, ch2;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_channel = 3'd0;
    sel_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      val_a[i] = 12'h100 + 12'(i);
      val_b[i] = 12'h000;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd1);
    check("rst_saddr", 32'(saddr_a), 32'd0);
    check("rst_rsp_valid", 32'(rspv_a), 32'd0);
    check("rst_rsp_data", 32'(rspd_a), 32'd0);
    check("rst_rsp_chan", 32'(rspch_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_state", 32'(dbg_a), 32'd0);
    check("rst_b_pins", 32'({cs_b, sclk_b, busy_b}), 32'h6);
    rst = 1'b0;

    // 1: first command after reset needs two frames; SADDR bits 2..4 = 101
    val_a[5] = 12'hA5C;
    run_cmd(1'b0, 3'd5, 2, 12'hA5C, 16'h2800, "sc1");

    // 2: repeated channel needs one frame
    val_a[5] = 12'h001;
    run_cmd(1'b0, 3'd5, 1, 12'h001, 16'h2800, "sc2");

    // 4: channel 7 held valid while a channel-5 command is in flight
    val_a[5] = 12'h0C3;
    val_a[7] = 12'h7E7;
    sel_b = 1'b0;
    @(negedge clk);
    check("sc4_ready0", 32'(ready_a), 32'd1);
    cmd_channel = 3'd5;
    cmd_valid = 1'b1;
    @(negedge clk);
    c0 = cyc;
    c1 = 0;
    cmd_channel = 3'd7;
    n_rsp = 0; bad_ready = 0; t_rsp1 = 0; t_rsp2 = 0; t_acc = 0; waited = 0;
    d1 = '0; d2 = '0; ch1 = '0; ch2 = '0;
    while (n_rsp < 2 && waited < 400 * DIV_A) begin
      if (rspv_a === 1'b1) begin
        n_rsp++;
        if (n_rsp == 1) begin t_rsp1 = cyc; d1 = rspd_a; ch1 = rspch_a; end
        else begin t_rsp2 = cyc; d2 = rspd_a; ch2 = rspch_a; end
      end
      if (ready_a === 1'b1 && busy_a === 1'b1) bad_ready++;
      if (cmd_valid && ready_a === 1'b1) begin
        t_acc = cyc;
        @(negedge clk);
        waited++;
        cmd_valid = 1'b0;
        c1 = cyc;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    check("sc4_rsp1_latency", 32'(t_rsp1 - c0), 32'(35 * DIV_A));
    check("sc4_rsp1_data", 32'(d1), 32'h0C3);
    check("sc4_rsp1_chan", 32'(ch1), 32'd5);
    check("sc4_accept_after_done", 32'(t_acc - t_rsp1), 32'd1);
    check("sc4_rsp2_latency", 32'(t_rsp2 - c1), 32'(70 * DIV_A));
    check("sc4_rsp2_data", 32'(d2), 32'h7E7);
    check("sc4_rsp2_chan", 32'(ch2), 32'd7);
    check("sc4_rsp_count", 32'(n_rsp), 32'd2);
    check("sc4_ready_while_busy", 32'(bad_ready), 32'd0);
    extra = 0;
    repeat (20) begin @(negedge clk); if (rspv_a === 1'b1) extra++; end
    check("sc4_no_extra_rsp", 32'(extra), 32'd0);

    // 3: channel change; the stale first-frame value must not be reported
    val_a[5] = 12'h555;
    run_cmd(1'b0, 3'd5, 2, 12'h555, 16'h2800, "sc3_ch5");
    val_a[2] = 12'h3FF;
    run_cmd(1'b0, 3'd2, 2, 12'h3FF, 16'h1000, "sc3_ch2");

    // 5: reset at k=8 abandons the frame and forgets the last address
    run_cmd(1'b0, 3'd5, 2, 12'h555, 16'h2800, "sc5_pre");
    @(negedge clk);
    cmd_channel = 3'd5;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (fall_a < 9 && waited < 100 * DIV_A) begin @(negedge clk); waited++; end
    check("sc5_reach_k8", 32'(fall_a), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    check("sc5_cs_n", 32'(cs_a), 32'd1);
    check("sc5_sclk", 32'(sclk_a), 32'd1);
    check("sc5_busy", 32'(busy_a), 32'd0);
    check("sc5_ready", 32'(ready_a), 32'd1);
    rst = 1'b0;
    val_a[5] = 12'h9B6;
    run_cmd(1'b0, 3'd5, 2, 12'h9B6, 16'h2800, "sc5_post");

    // 6: CLK_DIV=2, all-ones then all-zeros data with leading bits forced to 1
    val_b[1] = 12'hFFF;
    run_cmd(1'b1, 3'd1, 2, 12'hFFF, 16'h0800, "sc6_fff");
    check("sc6_sclk_period", 32'(per_b), 32'd4);
    check("sc6_sclk_low", 32'(low_b), 32'd2);
    val_b[1] = 12'h000;
    run_cmd(1'b1, 3'd1, 1, 12'h000, 16'h0800, "sc6_000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
